// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the memory-stage data bus bridge.
package dmem_bridge_pkg;

  // Bridge transaction state, 2-bit encoded
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2,
    HOLD      = 2'd3
  } state_e;

  // Bus size codes
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage : dmem_bridge_pkg

// File: rtl/dmem_bridge_if.sv
// SRAM-like data bus: request / address-ok / data-ok handshake.
interface dmem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // Bridge side: issues requests, receives handshakes and read data
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  // Memory agent side
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface : dmem_bridge_if

// File: rtl/dmem_size_enc.sv
// Maps an M-stage access onto the bus size code. Stores derive the size
// from the lane-aligned byte enables; loads pass their size code through.
module dmem_size_enc
  import dmem_bridge_pkg::*;
(
  input  logic       i_memwrite,
  input  logic [3:0] i_sig_write,
  input  logic [1:0] i_load_size,
  output logic [1:0] o_size
);

  // Size decode; unusual enable patterns fall back to a full word
  always_comb begin
    o_size = SZ_WORD;
    if (i_memwrite) begin
      case (i_sig_write)
        4'b1111:                            o_size = SZ_WORD;
        4'b0011, 4'b1100:                   o_size = SZ_HALF;
        4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = SZ_BYTE;
        default:                            o_size = SZ_WORD;
      endcase
    end else begin
      o_size = i_load_size;
    end
  end

endmodule : dmem_size_enc

// File: rtl/dmem_bridge.sv
// Memory-stage data bridge: converts the single-cycle M-stage access into
// one outstanding bus transaction, stalls the pipeline until the response
// arrives, and buffers the read data until the pipeline advances.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_enM,
  input  logic                memwriteM,
  input  logic [DATA_W/8-1:0] sig_write,
  input  logic [1:0]          load_sizeM,
  input  logic [ADDR_W-1:0]   aluoutM,
  input  logic [DATA_W-1:0]   writedataM,
  input  logic                flushM,
  input  logic                advanceM,
  output logic [DATA_W-1:0]   readdataM,
  output logic                stall_mem,
  dmem_bridge_if.master       bus
);

  state_e            r_state;
  state_e            w_next;
  logic              w_start;
  logic              w_capture;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_wdata_q;
  logic              r_wr_q;
  logic [1:0]        r_size_q;
  logic              r_discard_q;
  logic [DATA_W-1:0] r_readdata;

  assign w_start   = (r_state == IDLE) & mem_enM & ~flushM;
  assign readdataM = r_readdata;

  dmem_size_enc u_size_enc (
    .i_memwrite  (memwriteM),
    .i_sig_write (sig_write[3:0]),
    .i_load_size (load_sizeM),
    .o_size      (w_size)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a flushed transaction skips HOLD and drops its data
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (bus.data_addr_ok) begin
            w_next = WAIT_DATA;
          end else begin
            w_next = WAIT_ADDR;
          end
        end else begin
          w_next = IDLE;
        end
      end
      WAIT_ADDR: begin
        if (bus.data_addr_ok) begin
          w_next = WAIT_DATA;
        end else begin
          w_next = WAIT_ADDR;
        end
      end
      WAIT_DATA: begin
        if (bus.data_data_ok) begin
          if (r_discard_q | flushM) begin
            w_next = IDLE;
          end else begin
            w_next    = HOLD;
            w_capture = 1'b1;
          end
        end else begin
          w_next = WAIT_DATA;
        end
      end
      HOLD: begin
        if (advanceM) begin
          w_next = IDLE;
        end else begin
          w_next = HOLD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus fields: live M inputs while launching, latched copy afterwards
  always_comb begin
    bus.data_req   = 1'b0;
    bus.data_wr    = r_wr_q;
    bus.data_size  = r_size_q;
    bus.data_addr  = r_addr_q;
    bus.data_wdata = r_wdata_q;
    stall_mem      = 1'b0;
    case (r_state)
      IDLE: begin
        bus.data_req   = w_start;
        bus.data_wr    = memwriteM;
        bus.data_size  = w_size;
        bus.data_addr  = aluoutM;
        bus.data_wdata = memwriteM ? writedataM : {DATA_W{1'b0}};
        stall_mem      = w_start;
      end
      WAIT_ADDR: begin
        bus.data_req = 1'b1;
        stall_mem    = 1'b1;
      end
      WAIT_DATA: begin
        stall_mem = 1'b1;
      end
      HOLD: begin
        stall_mem = 1'b0;
      end
      default: begin
        stall_mem = 1'b0;
      end
    endcase
  end

  // Request latch, loaded when a transaction launches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_q  <= {ADDR_W{1'b0}};
      r_wdata_q <= {DATA_W{1'b0}};
      r_wr_q    <= 1'b0;
      r_size_q  <= SZ_BYTE;
    end else if (w_start) begin
      r_addr_q  <= aluoutM;
      r_wdata_q <= memwriteM ? writedataM : {DATA_W{1'b0}};
      r_wr_q    <= memwriteM;
      r_size_q  <= w_size;
    end
  end

  // Remembers a flush that arrived while the bus transaction was in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_discard_q <= 1'b0;
    end else if (r_state == IDLE) begin
      r_discard_q <= 1'b0;
    end else if (((r_state == WAIT_ADDR) || (r_state == WAIT_DATA)) && flushM) begin
      r_discard_q <= 1'b1;
    end
  end

  // Load data buffer, held until the next non-discarded response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_readdata <= {DATA_W{1'b0}};
    end else if (w_capture) begin
      r_readdata <= bus.data_rdata;
    end
  end

endmodule : dmem_bridge

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: directed transactions push expected
// bus requests and expected read data; monitors compare on DUT events.
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        mem_enM;
  logic        memwriteM;
  logic [3:0]  sig_write;
  logic [1:0]  load_sizeM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        flushM;
  logic        advanceM;
  logic [31:0] readdataM;
  logic        stall_mem;

  dmem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_enM    (mem_enM),
    .memwriteM  (memwriteM),
    .sig_write  (sig_write),
    .load_sizeM (load_sizeM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .flushM     (flushM),
    .advanceM   (advanceM),
    .readdataM  (readdataM),
    .stall_mem  (stall_mem),
    .bus        (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] rsp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rd  = 32'h0;
  logic        prev_stall = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Request monitor: every accepted request must match the scoreboard head
  always @(negedge clk) begin
    if (bus.data_req === 1'b1 && bus.data_addr_ok === 1'b1) begin
      if (req_q.size() == 0) begin
        chk("req_unexpected", 32'd1, 32'd0);
      end else begin
        req_t r;
        r = req_q.pop_front();
        chk("mon_addr",  bus.data_addr,  r.addr);
        chk("mon_wr",    32'(bus.data_wr),   32'(r.wr));
        chk("mon_size",  32'(bus.data_size), 32'(r.size));
        chk("mon_wdata", bus.data_wdata, r.wdata);
      end
    end
  end

  // Response monitor: when the stall drops, readdataM must hold the expected value
  always @(negedge clk) begin
    if (prev_stall && !stall_mem) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        chk("mon_readdata", readdataM, rsp_q.pop_front());
      end
    end
    prev_stall = stall_mem;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    mem_enM = 1'b0; memwriteM = 1'b0; sig_write = 4'h0; load_sizeM = 2'd0;
    aluoutM = 32'h0; writedataM = 32'h0; flushM = 1'b0; advanceM = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
  endtask

  // One full transaction with addr_ok delay and HOLD length; M inputs are
  // scrambled after launch so the latched copy is what must appear on the bus
  task automatic run_txn(input string nm, input logic wr, input logic [3:0] sw,
                         input logic [1:0] ls, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int addr_dly, input int hold_dly,
                         input logic [1:0] exp_size);
    req_t r;
    int   stalls;
    r.addr = addr; r.wr = wr; r.size = exp_size; r.wdata = wr ? wdata : 32'h0;
    req_q.push_back(r);
    rsp_q.push_back(rdata);
    mem_enM = 1'b1; memwriteM = wr; sig_write = sw; load_sizeM = ls;
    aluoutM = addr; writedataM = wdata; advanceM = 1'b0; flushM = 1'b0;
    stalls = 0;
    for (int i = 0; i <= addr_dly; i++) begin
      bus.data_addr_ok = (i == addr_dly);
      @(negedge clk);
      chk({nm, "_req"},   32'(bus.data_req), 32'd1);
      chk({nm, "_wr"},    32'(bus.data_wr), 32'(wr));
      chk({nm, "_size"},  32'(bus.data_size), 32'(exp_size));
      chk({nm, "_addr"},  bus.data_addr, addr);
      chk({nm, "_wdata"}, bus.data_wdata, r.wdata);
      if (stall_mem) stalls++;
      @(posedge clk); #1;
      aluoutM = ~addr; writedataM = ~wdata; sig_write = ~sw;
      load_sizeM = ~ls; memwriteM = ~wr;
    end
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
    @(negedge clk);
    chk({nm, "_req_wdata"}, 32'(bus.data_req), 32'd0);
    if (stall_mem) stalls++;
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0BAD0BAD;
    for (int h = 0; h <= hold_dly; h++) begin
      advanceM = (h == hold_dly);
      @(negedge clk);
      chk({nm, "_hold_stall"}, 32'(stall_mem), 32'd0);
      chk({nm, "_hold_req"},   32'(bus.data_req), 32'd0);
      chk({nm, "_hold_rd"},    readdataM, rdata);
      @(posedge clk); #1;
    end
    chk({nm, "_stall_cycles"}, 32'(stalls), 32'(addr_dly + 2));
    last_rd = rdata;
    clear_inputs();
    @(negedge clk);
    chk({nm, "_idle_req"},   32'(bus.data_req), 32'd0);
    chk({nm, "_idle_stall"}, 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
  endtask

  // Load flushed while in flight: bus completes it, no HOLD, readdataM kept
  task automatic run_flushed(input string nm, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic in_addr_phase);
    req_t r;
    r.addr = addr; r.wr = 1'b0; r.size = 2'd2; r.wdata = 32'h0;
    req_q.push_back(r);
    rsp_q.push_back(last_rd);
    mem_enM = 1'b1; memwriteM = 1'b0; load_sizeM = 2'd2; aluoutM = addr;
    bus.data_addr_ok = ~in_addr_phase;
    @(negedge clk);
    chk({nm, "_stall0"}, 32'(stall_mem), 32'd1);
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0; flushM = 1'b1;
    @(negedge clk);
    chk({nm, "_stall1"}, 32'(stall_mem), 32'd1);
    @(posedge clk); #1;
    flushM = 1'b0;
    if (in_addr_phase) begin
      bus.data_addr_ok = 1'b1;
      @(negedge clk);
      chk({nm, "_stall2"}, 32'(stall_mem), 32'd1);
      @(posedge clk); #1;
      bus.data_addr_ok = 1'b0;
    end
    bus.data_data_ok = 1'b1; bus.data_rdata = rdata;
    @(negedge clk);
    chk({nm, "_stall3"}, 32'(stall_mem), 32'd1);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk({nm, "_no_hold_stall"}, 32'(stall_mem), 32'd0);
    chk({nm, "_kept_rd"}, readdataM, last_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   32'(bus.data_req), 32'd0);
    chk("rst_wr",    32'(bus.data_wr), 32'd0);
    chk("rst_size",  32'(bus.data_size), 32'd0);
    chk("rst_addr",  bus.data_addr, 32'h0);
    chk("rst_wdata", bus.data_wdata, 32'h0);
    chk("rst_rd",    readdataM, 32'h0);
    chk("rst_stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //       name       wr    sw       ls    addr          wdata         rdata      adly hold size
    run_txn("ld_word", 1'b0, 4'h0,    2'd2, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 0, 0, 2'd2);
    run_txn("st_byte", 1'b1, 4'b0100, 2'd0, 32'h0000_0026, 32'h00AB_0000, 32'h5A5A0000, 3, 0, 2'd0);
    run_txn("st_half", 1'b1, 4'b1100, 2'd0, 32'h0000_0102, 32'hBEEF_0000, 32'h00000001, 1, 0, 2'd1);
    run_txn("st_word", 1'b1, 4'b1111, 2'd0, 32'h0000_0200, 32'h0102_0304, 32'h00000002, 0, 0, 2'd2);
    run_txn("st_b0",   1'b1, 4'b0001, 2'd0, 32'h0000_0203, 32'h0000_0077, 32'h00000003, 0, 0, 2'd0);
    run_txn("st_odd",  1'b1, 4'b0110, 2'd0, 32'h0000_0204, 32'h00CC_DD00, 32'h00000004, 0, 0, 2'd2);
    run_txn("st_lohalf", 1'b1, 4'b0011, 2'd0, 32'h0000_0208, 32'h0000_1234, 32'h00000005, 2, 0, 2'd1);
    run_txn("ld_byte", 1'b0, 4'h0,    2'd0, 32'h0000_0301, 32'h0,        32'h000000A5, 1, 0, 2'd0);
    run_txn("ld_half", 1'b0, 4'h0,    2'd1, 32'h0000_0302, 32'h0,        32'h0000C3C3, 2, 0, 2'd1);

    // Flush in IDLE suppresses the request entirely
    mem_enM = 1'b1; memwriteM = 1'b1; sig_write = 4'hF; aluoutM = 32'h300; flushM = 1'b1;
    @(negedge clk);
    chk("flush_idle_req",   32'(bus.data_req), 32'd0);
    chk("flush_idle_stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("flush_idle_after", 32'(bus.data_req), 32'd0);
    @(posedge clk); #1;
    run_txn("after_flush", 1'b0, 4'h0, 2'd2, 32'h0000_0400, 32'h0, 32'h11223344, 0, 0, 2'd2);

    run_flushed("flush_wdata", 32'h0000_0500, 32'h1234_5678, 1'b0);
    run_txn("post_fl_wd", 1'b0, 4'h0, 2'd2, 32'h0000_0504, 32'h0, 32'h55667788, 0, 0, 2'd2);
    run_flushed("flush_waddr", 32'h0000_0508, 32'h9999_0000, 1'b1);
    run_txn("hold5", 1'b0, 4'h0, 2'd2, 32'h0000_0600, 32'h0, 32'hA0B0C0D0, 0, 5, 2'd2);

    // Reset while waiting for addr_ok
    rsp_q.push_back(32'h0);
    mem_enM = 1'b1; memwriteM = 1'b1; sig_write = 4'hF; aluoutM = 32'h700;
    writedataM = 32'hFEED_FACE;
    @(negedge clk);
    chk("rst_mid_req_before", 32'(bus.data_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; mem_enM = 1'b0;
    #1;
    chk("rst_mid_req",   32'(bus.data_req), 32'd0);
    chk("rst_mid_stall", 32'(stall_mem), 32'd0);
    chk("rst_mid_rd",    readdataM, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b0;
    last_rd = 32'h0;
    @(posedge clk); #1;
    run_txn("post_rst", 1'b0, 4'h0, 2'd2, 32'h0000_0800, 32'h0, 32'h0F0F0F0F, 1, 0, 2'd2);

    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dmem_bridge

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Memory-stage data-side bus bridge. It sits directly downstream of the pipeline datapath.
- It turns the datapath's single-cycle M-stage access (memwrite, byte-enable, address, write data) into an SRAM-like request/address-ok/data-ok bus transaction.
- It returns read data to the datapath's readdataM input.
- It raises a stall to the hazard unit until the transaction has completed.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; sig_write width is DATA_W/8.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- mem_enM  in  1  M-stage instruction is a load or store.
- memwriteM  in  1  1 = store, 0 = load.
- sig_write  in  4  store byte enables, already lane-aligned.
- load_sizeM  in  2  load size code: 0 = byte, 1 = half, 2 = word.
- aluoutM  in  ADDR_W  byte address.
- writedataM  in  DATA_W  lane-aligned store data.
- flushM  in  1  kill the M-stage instruction.
- advanceM  in  1  pipeline moves M to W this cycle (~stallM).
- readdataM  out  DATA_W  buffered load data.
- stall_mem  out  1  stall request to the hazard unit.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  bus size code.
- data_addr  out  ADDR_W  bus address.
- data_wdata  out  DATA_W  bus write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response valid.
- data_rdata  in  DATA_W  response data.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All registers cleared: readdataM = 0, data_req = 0, data_wr = 0, data_size = 0, data_addr = 0, data_wdata = 0.
  - stall_mem = 0.
- States: IDLE, WAIT_ADDR, WAIT_DATA, HOLD.
- Request launch:
  - start = state == IDLE & mem_enM & ~flushM.
  - In IDLE, data_req = start. Bus fields are driven combinationally from the M inputs.
  - On start, the inputs are latched into addr_q, wdata_q, wr_q and size_q.
  - In WAIT_ADDR, data_req = 1 and the bus fields come from the latched registers. They stay stable until data_addr_ok.
- Size encoding:
  - Stores: sig_write 4'b1111 -> 2; 4'b0011 or 4'b1100 -> 1; one-hot -> 0; any other value -> 2.
  - Loads: data_size = load_sizeM; data_wdata is don't-care and is driven as 0.
- Transitions:
  - IDLE: start & data_addr_ok -> WAIT_DATA; start & ~data_addr_ok -> WAIT_ADDR.
  - WAIT_ADDR: data_addr_ok -> WAIT_DATA.
  - WAIT_DATA: data_data_ok -> HOLD, and readdataM <= data_rdata (also captured for stores; value is harmless).
  - HOLD: advanceM -> IDLE.
- data_data_ok is ignored outside WAIT_DATA. The bus never asserts it in the same cycle as the matching addr_ok.
- stall_mem = (state == IDLE & start) | state == WAIT_ADDR | state == WAIT_DATA.
  - It is 0 in HOLD, so the result is consumed on the next advanceM.
  - Minimum latency: addr_ok in the request cycle, data_ok one cycle later, consumed one cycle after that = 3 cycles from start to consumed.
- Only one outstanding transaction; no new request before HOLD -> IDLE.
- flushM:
  - In IDLE it suppresses the request; data_req = 0 and stall_mem = 0.
  - In WAIT_ADDR or WAIT_DATA it cannot cancel the bus transaction. The block completes it with stall_mem held, sets discard_q, then goes WAIT_DATA -> IDLE (skipping HOLD). readdataM is not updated.
- readdataM holds its value until the next capture.
- Reset mid-transaction returns to IDLE at once. The bus agent is reset together with the CPU.

Decomposition:
- Shared package holds:
  - State encoding (2-bit): IDLE = 0, WAIT_ADDR = 1, WAIT_DATA = 2, HOLD = 3.
  - Size codes: SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
- One sub-module, dmem_size_enc: combinational map from sig_write/load_sizeM/memwriteM to data_size.
- FSM and latches stay in dmem_bridge.

Test Plan:
- Load word, addr 0x0000_0010; addr_ok in the request cycle, data_ok next cycle with 0xDEAD_BEEF.
  -> stall_mem high 2 cycles, then readdataM = 0xDEADBEEF in HOLD; advanceM -> IDLE.
- Store byte, sig_write 4'b0100, wdata 0x00AB_0000; addr_ok delayed 3 cycles.
  -> data_req held 4 cycles with data_addr, data_wdata and data_size = 0 stable; data_wr = 1.
- Store half, sig_write 4'b1100, then sig_write 4'b1111.
  -> data_size = 1, then data_size = 2.
- flushM asserted in IDLE with mem_enM = 1.
  -> data_req = 0, stall_mem = 0, state stays IDLE.
- flushM asserted in WAIT_DATA; data_ok arrives with 0x1234_5678.
  -> returns to IDLE, readdataM keeps its previous value, no HOLD cycle.
- HOLD with advanceM = 0 for 5 cycles.
  -> stall_mem = 0, no new data_req, readdataM stable; rst pulsed mid-WAIT_ADDR -> data_req = 0 immediately.
